rfid_wb_sequencer: RTL
======================

// Module: rfid_wb_sequencer
// PURPOSE
//   Wishbone classic bus master for the RFID peripheral subsystem (SPI + I2C cores).
//   Arbitrates round-robin between two command requesters:
//     - r0: the protocol engine.
//     - r1: the host/debug port.
//   Issues one single-beat register access per command on the shared cyc/stb/adr/we/dat bus.
//   Returns read data or an error on a response channel, with ack timeout.
// PARAMETERS
//   ADR_W    3    Wishbone address width (I2C uses 3 bits, SPI uses adr[1:0]).
//   DAT_W    8    Wishbone data width.
//   TO_W     8    Timeout counter width.
//   TIMEOUT  255  Max cycles waiting for ack in BUS; 0 disables the timeout.
// PORTS
//   clk        in   1      System clock.
//   rst        in   1      Asynchronous, active-low reset.
//   r0_valid   in   1      Requester 0 command valid.
//   r0_ready   out  1      Requester 0 command accepted (valid&ready = transfer).
//   r0_tgt     in   1      Target: 0 = SPI (stb[0]), 1 = I2C (stb[1]).
//   r0_adr     in   ADR_W  Register address.
//   r0_we      in   1      1 = write, 0 = read.
//   r0_dat     in   DAT_W  Write data.
//   r1_*       -    -      Same set as r0_* for requester 1.
//   rsp_valid  out  1      Response valid; held until rsp_ready.
//   rsp_ready  in   1      Response consumer ready.
//   rsp_id     out  1      Requester index the response belongs to.
//   rsp_dat    out  DAT_W  Read data (0 for writes and errors).
//   rsp_err    out  1      1 = ack timeout.
//   cyc        out  1      Wishbone cycle.
//   stb        out  2      One-hot strobe: [0] = SPI, [1] = I2C.
//   adr        out  ADR_W  Wishbone address.
//   we         out  1      Wishbone write enable.
//   dat        out  DAT_W  Wishbone write data.
//   dat_i_spi  in   DAT_W  SPI read data.
//   ack_i_spi  in   1      SPI ack.
//   dat_i_i2c  in   DAT_W  I2C read data.
//   ack_i_i2c  in   1      I2C ack.
//   busy       out  1      High in any state other than IDLE.
// BEHAVIOUR
//   Reset (rst=0, async)
//     - State IDLE; all outputs 0; rr pointer selects r0 first.
//     - Reset mid-BUS drops cyc/stb immediately; the in-flight command and any pending
//       response are discarded.
//   FSM: IDLE -> BUS -> RESP -> IDLE. All Wishbone outputs and rsp_* are registered.
//   IDLE
//     - rX_ready is combinational, asserted only for the granted requester and only in IDLE.
//     - Grant: if both valid, take the one not granted last; otherwise take the single valid one.
//     - On transfer, latch tgt/adr/we/dat/id, update the pointer, go to BUS.
//     - Next cycle: cyc=1, stb[tgt]=1, adr/we/dat driven.
//   BUS
//     - Wait for the ack of the selected target only; ignore the other target's ack.
//     - On the ack edge:
//       - Capture the selected dat_i when we=0; capture 0 when we=1.
//       - Deassert cyc/stb at that same edge, so stb is never high in the cycle after ack
//         and no double access occurs.
//       - rsp_err=0; go to RESP.
//     - Timeout counter clears on BUS entry and increments each BUS cycle. When it reaches
//       TIMEOUT (TIMEOUT>0), drop cyc/stb, set rsp_err=1 and rsp_dat=0, go to RESP.
//     - Ack and timeout in the same cycle: ack wins, rsp_err=0.
//   RESP
//     - rsp_valid=1 with stable rsp_*; on rsp_ready, clear rsp_valid and go to IDLE.
//     - No new command is accepted until IDLE; one access outstanding at most.
//   Latency with a 1-cycle-ack slave and rsp_ready tied high:
//     - Accept at T0, cyc/stb at T1, ack at T2, rsp_valid at T3, back in IDLE at T4
//       (accepting again at T4).
//   Fairness
//     - Under continuous contention, grants alternate r0, r1, r0, ...
//     - A lone requester is granted back-to-back.
//   Commands are not sanity-checked; adr passes through unchanged (SPI ignores adr[2]).
// STRUCTURE
//   Shared include rfid_wb_defs.vh:
//     - State encodings ST_IDLE, ST_BUS, ST_RESP.
//     - TGT_SPI=0, TGT_I2C=1.
//     - Default ADR_W/DAT_W.
//   Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], advance -> gnt[1:0], last pointer).
//   Top-level FSM, command latch, timeout counter and response register live in this module.
// TESTING
//   1. Write r0 SPI adr=2 dat=0xA5; ack after 1 cycle
//      -> stb=2'b01 for exactly 1 cycle, adr=2, we=1, dat=0xA5;
//         rsp id=0, dat=0x00, err=0 at T3.
//   2. Read r1 I2C adr=4; slave returns 0x3C with ack after 3 cycles
//      -> stb=2'b10, rsp id=1, dat=0x3C, err=0.
//   3. r0 and r1 valid continuously for 4 commands
//      -> grant order r0, r1, r0, r1; rsp_id follows that order.
//   4. TIMEOUT=4, slave never acks
//      -> cyc drops after 4 BUS cycles; rsp err=1, dat=0; next command proceeds normally.
//   5. SPI selected, ack_i_i2c pulses while ack_i_spi stays low for 2 cycles
//      -> I2C ack ignored; completion only on ack_i_spi.
//   6. rsp_ready low 5 cycles; r1 valid meanwhile, then async reset asserted mid-BUS
//      -> rsp held stable and r1_ready=0 while rsp_ready is low;
//         on reset cyc/stb/rsp_valid=0 immediately, and r0 wins first after release.

Source files
------------

// File: rtl/rfid_wb_sequencer_pkg.sv
// Shared definitions for the RFID Wishbone sequencer: FSM states, target codes
// and default bus widths.
package rfid_wb_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic TGT_SPI = 1'b0;
    localparam logic TGT_I2C = 1'b1;

    localparam int DEF_ADR_W = 3;
    localparam int DEF_DAT_W = 8;

    // One-hot strobe for a target: bit 0 = SPI, bit 1 = I2C.
    function automatic logic [1:0] tgt_onehot(input logic tgt);
        return (tgt == TGT_I2C) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rfid_wb_sequencer_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers who was granted last so
// that under contention the other requester wins next; a lone requester is
// always granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Index of the requester granted most recently; resets to 1 so r0 goes first.
    logic last;

    // Grant: contention goes to the one not served last, otherwise the single requester.
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
    end

    // Pointer moves only when a grant is actually consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last <= 1'b1;
        else if (advance)
            last <= gnt[1];
    end

endmodule

// File: rtl/rfid_wb_sequencer.sv
// Wishbone classic master for the RFID SPI/I2C cores. Two requesters share one
// single-beat access at a time; each access yields one response, with an ack
// timeout turning a dead slave into an error response.
module rfid_wb_sequencer
    import rfid_wb_sequencer_pkg::*;
#(
    parameter int ADR_W   = DEF_ADR_W,
    parameter int DAT_W   = DEF_DAT_W,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic             r0_tgt,
    input  logic [ADR_W-1:0] r0_adr,
    input  logic             r0_we,
    input  logic [DAT_W-1:0] r0_dat,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic             r1_tgt,
    input  logic [ADR_W-1:0] r1_adr,
    input  logic             r1_we,
    input  logic [DAT_W-1:0] r1_dat,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             cyc,
    output logic [1:0]       stb,
    output logic [ADR_W-1:0] adr,
    output logic             we,
    output logic [DAT_W-1:0] dat,
    input  logic [DAT_W-1:0] dat_i_spi,
    input  logic             ack_i_spi,
    input  logic [DAT_W-1:0] dat_i_i2c,
    input  logic             ack_i_i2c,
    output logic             busy
);

    typedef struct packed {
        logic             tgt;
        logic [ADR_W-1:0] adr;
        logic             we;
        logic [DAT_W-1:0] dat;
    } cmd_t;

    state_t           state;
    logic             tgt_q;
    logic             id_q;
    logic [TO_W-1:0]  to_cnt;
    logic [1:0]       gnt;
    logic             idle;
    logic             take;
    cmd_t             sel;
    logic             ack_sel;
    logic [DAT_W-1:0] dat_sel;
    logic             to_hit;

    assign idle = (state == ST_IDLE);
    assign take = idle && (gnt != 2'b00);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({r1_valid, r0_valid}),
        .advance (take),
        .gnt     (gnt)
    );

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign r0_ready = rst && idle && gnt[0];
    assign r1_ready = rst && idle && gnt[1];
    assign busy     = !idle;

    assign sel = gnt[1] ? cmd_t'{r1_tgt, r1_adr, r1_we, r1_dat}
                        : cmd_t'{r0_tgt, r0_adr, r0_we, r0_dat};

    // Only the addressed slave may complete the cycle.
    assign ack_sel = (tgt_q == TGT_I2C) ? ack_i_i2c : ack_i_spi;
    assign dat_sel = (tgt_q == TGT_I2C) ? dat_i_i2c : dat_i_spi;

    // Counter starts at 0 in the first BUS cycle, so a hit here means TIMEOUT
    // BUS cycles have elapsed with no ack.
    assign to_hit = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));

    // Sequencer FSM: accept one command, run one Wishbone beat, hold the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            tgt_q     <= TGT_SPI;
            id_q      <= 1'b0;
            to_cnt    <= '0;
            cyc       <= 1'b0;
            stb       <= 2'b00;
            adr       <= '0;
            we        <= 1'b0;
            dat       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        tgt_q  <= sel.tgt;
                        id_q   <= gnt[1];
                        adr    <= sel.adr;
                        we     <= sel.we;
                        dat    <= sel.dat;
                        cyc    <= 1'b1;
                        stb    <= tgt_onehot(sel.tgt);
                        to_cnt <= '0;
                        state  <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Ack is checked first so it wins a tie with the timeout.
                    if (ack_sel) begin
                        cyc       <= 1'b0;
                        stb       <= 2'b00;
                        rsp_dat   <= we ? '0 : dat_sel;
                        rsp_err   <= 1'b0;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (to_hit) begin
                        cyc       <= 1'b0;
                        stb       <= 2'b00;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
